// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity, stop bit(s).
// Runs at the baud tick rate, so every clk period is exactly one bit time on tx_out.
module uart_tx_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic                  ready,
  output logic                  busy,
  output logic                  tx_out,
  output logic                  frame_done
);

  // The counter is shared between data bits and stop bits; STOP_BITS <= 2 always fits.
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic last_data;
  logic last_stop;
  logic accept;

  // Handshake decode: ready is combinational so a waiting caller is taken in the last stop cycle.
  always_comb begin
    last_data = (cnt_q == CntW'(DATA_WIDTH - 1));
    last_stop = (state_q == StStop) && (cnt_q == CntW'(STOP_BITS - 1));
    ready     = (state_q == StIdle) || last_stop;
    accept    = data_valid && ready;
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StStart: begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (last_data) begin
          cnt_d   = '0;
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        state_d = StStop;
        cnt_d   = '0;
      end
      StStop: begin
        if (last_stop) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Acceptance overrides: from IDLE, or back-to-back from the final stop cycle.
    if (accept) begin
      state_d   = StStart;
      cnt_d     = '0;
      shift_d   = parallel_data;
      par_en_d  = par_en;
      // Odd parity is the complement of the even-parity XOR reduction.
      par_bit_d = (^parallel_data) ^ par_type;
    end

    // tx_out is registered, so it is computed for the state being entered.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != StIdle);
    done_d = last_stop;
  end

  // State and output registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: two instances (1 and 2 stop bits) checked cycle by cycle
// against a line-level model built from frame rules.
module tb_uart_tx_controller;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       dv1, pe1, pt1, rdy1, busy1, tx1, fd1;
  logic [7:0] d1;
  logic       dv2, pe2, pt2, rdy2, busy2, tx2, fd2;
  logic [7:0] d2;

  uart_tx_controller #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .data_valid(dv1), .parallel_data(d1), .par_en(pe1),
    .par_type(pt1), .ready(rdy1), .busy(busy1), .tx_out(tx1), .frame_done(fd1)
  );

  uart_tx_controller #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .data_valid(dv2), .parallel_data(d2), .par_en(pe2),
    .par_type(pt2), .ready(rdy2), .busy(busy2), .tx_out(tx2), .frame_done(fd2)
  );

  typedef struct packed {
    logic tx;
    logic busy;
    logic fd;
    logic rdy;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] f_data[$];
  bit         f_pe[$];
  bit         f_pt[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic drive(input int sel, input logic dv, input logic [7:0] d, input logic pe,
                       input logic pt);
    if (sel == 1) begin
      dv2 = dv; d2 = d; pe2 = pe; pt2 = pt;
    end else begin
      dv1 = dv; d1 = d; pe1 = pe; pt1 = pt;
    end
  endtask

  task automatic add(input logic [7:0] d, input bit pe, input bit pt);
    f_data.push_back(d);
    f_pe.push_back(pe);
    f_pt.push_back(pt);
  endtask

  // Line model: one entry per bit time, straight from the frame definition.
  task automatic add_frame(input int sel, input logic [7:0] d, input bit pe, input bit pt,
                           input bit follows);
    logic bits[$];
    int   ones;
    cyc_t c;
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    // Parity bit makes the total count of ones even (pt=0) or odd (pt=1).
    if (pe) bits.push_back(((ones % 2) == 1) ^ pt);
    for (int s = 0; s < sel + 1; s++) bits.push_back(1'b1);
    for (int t = 0; t < bits.size(); t++) begin
      c.tx   = bits[t];
      c.busy = 1'b1;
      c.fd   = follows && (t == 0);
      c.rdy  = (t == bits.size() - 1);
      exp_q.push_back(c);
    end
  endtask

  // Send the queued frames with data_valid held; optionally pulse a stray request at cycle pulse_at.
  task automatic run(input int sel, input int pulse_at);
    int   n;
    int   j;
    bit   acc;
    cyc_t idle;
    n = f_data.size();
    exp_q.delete();
    for (int k = 0; k < n; k++) add_frame(sel, f_data[k], f_pe[k], f_pt[k], k > 0);
    idle = '{tx: 1'b1, busy: 1'b0, fd: 1'b1, rdy: 1'b1};
    exp_q.push_back(idle);
    idle.fd = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(idle);
    j = 0;
    @(negedge clk);
    drive(sel, 1'b1, f_data[0], f_pe[0], f_pt[0]);
    for (int c = 0; c < exp_q.size(); c++) begin
      acc = (sel == 1) ? (rdy2 && dv2) : (rdy1 && dv1);
      @(posedge clk);
      #1;
      if (acc) begin
        j++;
        if (j < n) drive(sel, 1'b1, f_data[j], f_pe[j], f_pt[j]);
        else drive(sel, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      end else if (c == pulse_at + 1) begin
        drive(sel, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      if (c == pulse_at) drive(sel, 1'b1, 8'hFF, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("s%0d c%0d tx", sel, c), (sel == 1) ? tx2 : tx1, exp_q[c].tx);
      check($sformatf("s%0d c%0d busy", sel, c), (sel == 1) ? busy2 : busy1, exp_q[c].busy);
      check($sformatf("s%0d c%0d frame_done", sel, c), (sel == 1) ? fd2 : fd1, exp_q[c].fd);
      check($sformatf("s%0d c%0d ready", sel, c), (sel == 1) ? rdy2 : rdy1, exp_q[c].rdy);
    end
    f_data.delete();
    f_pe.delete();
    f_pt.delete();
  endtask

  initial begin
    int n;
    int sel;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset tx1", tx1, 1'b1);
    check("reset busy1", busy1, 1'b0);
    check("reset fd1", fd1, 1'b0);
    check("reset rdy1", rdy1, 1'b1);
    check("reset tx2", tx2, 1'b1);
    check("reset busy2", busy2, 1'b0);
    reset_n = 1'b1;

    // Reset in the middle of DATA: line back to 1 without waiting for a clock edge.
    @(negedge clk);
    drive(0, 1'b1, 8'hA5, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre-abort busy", busy1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("abort tx", tx1, 1'b1);
    check("abort busy", busy1, 1'b0);
    @(negedge clk);
    check("abort frame_done", fd1, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-abort tx", tx1, 1'b1);
    check("post-abort busy", busy1, 1'b0);
    check("post-abort frame_done", fd1, 1'b0);
    check("post-abort ready", rdy1, 1'b1);

    // Even and odd parity frames.
    add(8'hA5, 1'b1, 1'b0); run(0, -1000);
    add(8'hA5, 1'b1, 1'b1); run(0, -1000);
    add(8'h01, 1'b1, 1'b1); run(0, -1000);
    // Two stop bits, no parity slot.
    add(8'h3C, 1'b0, 1'b0); run(1, -1000);
    // Back-to-back frames with data_valid held.
    add(8'h55, 1'b0, 1'b0); add(8'hAA, 1'b0, 1'b0); run(0, -1000);
    add(8'h55, 1'b1, 1'b1); add(8'hAA, 1'b1, 1'b0); run(1, -1000);
    // Stray request while busy is ignored.
    add(8'h12, 1'b0, 1'b0); run(0, 3);
    add(8'h9E, 1'b1, 1'b0); run(1, 5);

    // Randomized bursts on either instance.
    for (int r = 0; r < 10; r++) begin
      sel = int'($urandom_range(1, 0));
      n   = int'($urandom_range(3, 1));
      for (int k = 0; k < n; k++) add(8'($urandom), 1'($urandom), 1'($urandom));
      run(sel, -1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
